// File: rtl/serial_lane_arbiter_pkg.sv
// Shared types and constants for the serial lane arbiter.
// Optional statistics counters are enabled with SERIAL_ARB_STATS_EN.
package serial_arb_pkg;

    localparam int MAX_LANES = 8;
    localparam int STAT_W    = 16;

    typedef enum logic [1:0] {
        IDLE,
        LEN,
        PAY
    } arbState_e;

    // Population count of a lane vector, used to tally refused requests per cycle
    function automatic logic [3:0] countOnes(input logic [MAX_LANES-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/serial_lane_arbiter_if.sv
// Lane-side and output-side signals of the serial lane arbiter.
// The master drives the lanes; the slave is the arbiter itself.
interface serial_lane_arbiter_if #(
    parameter int NUM_LANES = 4
);
    logic [NUM_LANES-1:0] serIn;
    logic [NUM_LANES-1:0] seqValid;
    logic                 serOut;
    logic                 outputValid;
    logic [NUM_LANES-1:0] grant;
    logic                 busy;
    logic [NUM_LANES-1:0] dropped;

    modport master (
        output serIn, seqValid,
        input  serOut, outputValid, grant, busy, dropped
    );

    modport slave (
        input  serIn, seqValid,
        output serOut, outputValid, grant, busy, dropped
    );
endinterface

// File: rtl/serial_lane_arbiter_rr_picker.sv
// Combinational round-robin selector: searches upward from the lane after ptr
// and returns the first requesting lane as one-hot plus its index.
module rr_picker
    import serial_arb_pkg::*;
#(
    parameter  int NUM_LANES = 4,
    localparam int PTR_W     = $clog2(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_LANES-1:0] winner,
    output logic [PTR_W-1:0]     winIdx,
    output logic                 valid
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        winner = '0;
        winIdx = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NUM_LANES; i++) begin
            idx = PTR_W'((int'(ptr) + i) % NUM_LANES);
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                winIdx      = idx;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_lane_arbiter.sv
// Shares one serial frame path between several lanes: grants a lane on header
// detect, reads its length field, then forwards that many payload bits.
// Define SERIAL_ARB_STATS_EN to add frame_count/drop_count statistics outputs.
module serial_lane_arbiter
    import serial_arb_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int LEN_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_lane_arbiter_if.slave bus
`ifdef SERIAL_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]    frame_count,
    output logic [STAT_W-1:0]    drop_count
`endif
);

    localparam int PTR_W = $clog2(NUM_LANES);
    localparam int BIT_W = $clog2(LEN_BITS);

    arbState_e            state, stateNext;
    logic [NUM_LANES-1:0] grantReg, grantNext;
    logic [NUM_LANES-1:0] droppedReg, droppedNext;
    logic [NUM_LANES-1:0] winner;
    logic [LEN_BITS-1:0]  lenReg, lenNext;
    logic [LEN_BITS-1:0]  count, countNext;
    logic [LEN_BITS-1:0]  newLen;
    logic [BIT_W-1:0]     bitCnt, bitCntNext;
    logic [PTR_W-1:0]     rrPtr, rrPtrNext, winIdx;
    logic                 winValid, free, accept, grantedBit, lastPayBit;

    rr_picker #(.NUM_LANES(NUM_LANES)) picker (
        .req    (bus.seqValid),
        .ptr    (rrPtr),
        .winner (winner),
        .winIdx (winIdx),
        .valid  (winValid)
    );

    // The final payload bit frees the path so a new header can follow without a gap
    assign grantedBit = |(bus.serIn & grantReg);
    assign lastPayBit = (state == PAY) && (count == LEN_BITS'(1));
    assign free       = (state == IDLE) || lastPayBit;
    assign accept     = free && winValid;
    assign newLen     = {lenReg[LEN_BITS-2:0], grantedBit};

    assign bus.grant       = grantReg;
    assign bus.busy        = (state != IDLE);
    assign bus.outputValid = (state == PAY);
    assign bus.serOut      = (state == PAY) & grantedBit;
    assign bus.dropped     = droppedReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grantReg   <= '0;
            droppedReg <= '0;
            lenReg     <= '0;
            count      <= '0;
            bitCnt     <= '0;
            rrPtr      <= PTR_W'(NUM_LANES - 1);
        end else begin
            state      <= stateNext;
            grantReg   <= grantNext;
            droppedReg <= droppedNext;
            lenReg     <= lenNext;
            count      <= countNext;
            bitCnt     <= bitCntNext;
            rrPtr      <= rrPtrNext;
        end
    end

    always_comb begin
        stateNext   = state;
        grantNext   = grantReg;
        lenNext     = lenReg;
        countNext   = count;
        bitCntNext  = bitCnt;
        rrPtrNext   = rrPtr;
        droppedNext = bus.seqValid & ~(accept ? winner : '0);

        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext  = LEN;
                    grantNext  = winner;
                    rrPtrNext  = winIdx;
                    bitCntNext = '0;
                end
            end
            LEN: begin
                lenNext    = newLen;
                bitCntNext = bitCnt + BIT_W'(1);
                if (bitCnt == BIT_W'(LEN_BITS - 1)) begin
                    bitCntNext = '0;
                    if (newLen == '0) begin
                        stateNext = IDLE;
                        grantNext = '0;
                    end else begin
                        stateNext = PAY;
                        countNext = newLen;
                    end
                end
            end
            PAY: begin
                countNext = count - LEN_BITS'(1);
                if (lastPayBit) begin
                    if (accept) begin
                        stateNext  = LEN;
                        grantNext  = winner;
                        rrPtrNext  = winIdx;
                        bitCntNext = '0;
                    end else begin
                        stateNext = IDLE;
                        grantNext = '0;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
                grantNext = '0;
            end
        endcase
    end

`ifdef SERIAL_ARB_STATS_EN
    logic [STAT_W:0] dropSum;

    assign dropSum = {1'b0, drop_count} + (STAT_W + 1)'(countOnes(MAX_LANES'(droppedReg)));

    // Both counters stick at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            if (lastPayBit && (frame_count != '1)) begin
                frame_count <= frame_count + STAT_W'(1);
            end
            drop_count <= dropSum[STAT_W] ? '1 : dropSum[STAT_W-1:0];
        end
    end
`endif

endmodule
